// File: rtl/sample_rom_if.sv
// Sample ROM address/data port: the player drives the address counter controls,
// the ROM returns the byte at the current counter position.
interface sample_rom_if;
    logic [15:0] sample_addr_out;
    logic [1:0]  sample_addr_wr;
    logic        sample_inc;
    logic [7:0]  sample_data;

    modport master (
        output sample_addr_out,
        output sample_addr_wr,
        output sample_inc,
        input  sample_data
    );

    modport slave (
        input  sample_addr_out,
        input  sample_addr_wr,
        input  sample_inc,
        output sample_data
    );
endinterface

// File: rtl/sample_player.sv
// 8-bit PCM sample playback engine: loads the ROM address counter, fetches one
// byte per playback strobe, and stops on a 0x00 marker, a stop request or a length cap.
module sample_player #(
    parameter int unsigned MAX_LEN = 131072,
    parameter logic [7:0]  SILENCE = 8'h80
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         ce_sample,
    input  logic         start,
    input  logic [12:0]  start_addr,
    input  logic         stop,
    sample_rom_if.master rom,
    output logic [7:0]   dac_out,
    output logic         dac_valid,
    output logic         busy,
    output logic         done
);
    localparam logic [17:0] MAX_LEN_C = 18'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_PLAY   = 3'd3,
        ST_INC    = 3'd4,
        ST_SETTLE = 3'd5
    } state_t;

    state_t      state_r;
    state_t      next_s;
    logic [17:0] byte_cnt_r;
    logic        pending_r;
    logic [15:0] addr_out_r;
    logic [1:0]  addr_wr_r;
    logic        inc_r;
    logic [7:0]  dac_out_r;
    logic        dac_valid_r;
    logic        busy_r;
    logic        done_r;
    logic        service_s;
    logic        marker_s;
    logic        limit_s;
    logic        fetch_state_s;

    // Next-state logic: start beats stop, stop beats strobe servicing.
    always_comb begin
        service_s     = (state_r == ST_PLAY) && (ce_sample || pending_r);
        marker_s      = (rom.sample_data == 8'h00);
        limit_s       = ((byte_cnt_r + 18'd1) == MAX_LEN_C);
        fetch_state_s = (state_r == ST_LOAD) || (state_r == ST_WAIT) ||
                        (state_r == ST_INC)  || (state_r == ST_SETTLE);
        next_s        = state_r;
        if (start) begin
            next_s = ST_LOAD;
        end else if (stop && (state_r != ST_IDLE)) begin
            next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE:   next_s = ST_IDLE;
                ST_LOAD:   next_s = ST_WAIT;
                ST_WAIT:   next_s = ST_PLAY;
                ST_PLAY: begin
                    if (!service_s) begin
                        next_s = ST_PLAY;
                    end else if (marker_s || limit_s) begin
                        next_s = ST_IDLE;
                    end else begin
                        next_s = ST_INC;
                    end
                end
                ST_INC:    next_s = ST_SETTLE;
                ST_SETTLE: next_s = ST_PLAY;
                default:   next_s = ST_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_s;
        end
    end

    // ROM control outputs are decoded from the next state so they line up with LOAD/INC.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_out_r <= 16'h0000;
            addr_wr_r  <= 2'b00;
            inc_r      <= 1'b0;
            busy_r     <= 1'b0;
            pending_r  <= 1'b0;
        end else begin
            addr_wr_r <= (next_s == ST_LOAD) ? 2'b11 : 2'b00;
            inc_r     <= (next_s == ST_INC);
            busy_r    <= (next_s != ST_IDLE);
            if (start) begin
                addr_out_r <= {3'b000, start_addr};
            end else begin
                addr_out_r <= addr_out_r;
            end
            // One-deep strobe memory covering the cycles where ROM data is not yet valid.
            if (start || (next_s == ST_IDLE) || service_s) begin
                pending_r <= 1'b0;
            end else if (ce_sample && fetch_state_s) begin
                pending_r <= 1'b1;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    // Sample output, byte counter and end-of-playback pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            dac_out_r   <= SILENCE;
            dac_valid_r <= 1'b0;
            done_r      <= 1'b0;
            byte_cnt_r  <= 18'd0;
        end else begin
            dac_valid_r <= 1'b0;
            done_r      <= 1'b0;
            if (start) begin
                byte_cnt_r <= 18'd0;
            end else if ((state_r == ST_IDLE) || stop) begin
                dac_out_r <= SILENCE;
            end else if (service_s) begin
                if (marker_s) begin
                    dac_out_r <= SILENCE;
                    done_r    <= 1'b1;
                end else begin
                    dac_out_r   <= rom.sample_data;
                    dac_valid_r <= 1'b1;
                    byte_cnt_r  <= byte_cnt_r + 18'd1;
                    done_r      <= limit_s;
                end
            end else begin
                dac_out_r <= dac_out_r;
            end
        end
    end

    assign rom.sample_addr_out = addr_out_r;
    assign rom.sample_addr_wr  = addr_wr_r;
    assign rom.sample_inc      = inc_r;
    assign dac_out             = dac_out_r;
    assign dac_valid           = dac_valid_r;
    assign busy                = busy_r;
    assign done                = done_r;
endmodule
